sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 18, meaning SRAM word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning SRAM data width.
REQ-003 Port clk  input  1  single system clock (pixel clock x6); all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port clkPhase  input  3  pixel-period slot, 0..5, advancing once per clk.
REQ-006 Port rd_req  input  1  one-cycle read request strobe.
REQ-007 Port rd_addr  input  ADDR_W  read address, sampled with rd_req.
REQ-008 Port rd_busy  output  1  read request pending or in service.
REQ-009 Port rd_data  output  DATA_W  returned read word.
REQ-010 Port rd_valid  output  1  one-cycle strobe marking rd_data valid.
REQ-011 Port wr_req  input  1  one-cycle write request strobe.
REQ-012 Port wr_addr  input  ADDR_W  write address, sampled with wr_req.
REQ-013 Port wr_data  input  DATA_W  write word, sampled with wr_req.
REQ-014 Port wr_busy  output  1  write request pending or in service.
REQ-015 Port overrun  output  2  sticky drop flags, bit0 read, bit1 write.
REQ-016 Port overrun_clr  input  1  clears both overrun bits.
REQ-017 Ports sram_addr (output ADDR_W), sram_wdata (output DATA_W), sram_rdata (input DATA_W), sram_drive (output 1, data-bus output enable for the top-level tristate), sram_oe_n, sram_we_n, sram_ce_n (outputs 1, active-low strobes).

Function
REQ-018 Each port SHALL hold a one-deep pending slot; req while the slot is empty SHALL capture address (and data) and set busy on the next cycle.
REQ-019 req while the slot is occupied SHALL be dropped and SHALL set the matching overrun bit; overrun_clr and a drop in the same cycle SHALL leave the bit set.
REQ-020 The read window SHALL be phases 0-2 and the write window phases 3-5; the slot owning the window at the edge where clkPhase equals 0 (read) or 3 (write) SHALL be serviced; otherwise that window SHALL stay idle.
REQ-021 Read window: cycles following phase-0, phase-1 edges SHALL drive sram_addr=addr, sram_ce_n=0, sram_oe_n=0, sram_drive=0; at the phase-2 edge sram_rdata SHALL be registered into rd_data, rd_valid SHALL pulse for one cycle, oe_n/ce_n SHALL return high, and rd_busy SHALL clear.
REQ-022 Write window: after the phase-3 edge, sram_addr, sram_wdata SHALL be driven, sram_drive=1, sram_ce_n=0, sram_we_n=1; after the phase-4 edge sram_we_n=0; after the phase-5 edge sram_we_n=1 with addr/data/drive held one further cycle, then sram_drive=0, ce_n=1, wr_busy cleared.
REQ-023 sram_oe_n and sram_drive SHALL never be simultaneously active; sram_we_n SHALL be low only while sram_drive=1 and address is stable.
REQ-024 A request captured during its own window SHALL wait for the next window (no mid-window start); worst-case latency req-to-rd_valid SHALL be 9 cycles.
REQ-025 A slot SHALL accept a new req in the same cycle busy clears (rd_valid cycle / write completion cycle).
REQ-026 clkPhase values 6 or 7 SHALL abort any access in progress: strobes high, sram_drive=0, pending slots retained for retry.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Asserting reset_n low SHALL immediately force sram_ce_n=sram_oe_n=sram_we_n=1, sram_drive=0, rd_valid=0, rd_busy=wr_busy=0, overrun=0, rd_data=0, sram_addr=0, sram_wdata=0, and empty both slots, including mid-access.
REQ-029 After release, the first access SHALL begin no earlier than the next phase-0 or phase-3 edge.

Structure
REQ-030 Phase constants (RD_START=0, RD_SAMPLE=2, WR_START=3, WR_PULSE=4, WR_END=5) and the window-state enumeration SHALL live in shared package sramfb_pkg.
REQ-031 The pending slot SHALL be one sub-module, req_slot, instantiated twice (read: data width 0 unused; write: DATA_W).

Verification
REQ-032 rd_req addr 0x01234 at phase 4, sram_rdata model returns 0xBEEF -> oe_n low phases 0-1 next period, rd_data=0xBEEF, rd_valid one cycle after phase-2 edge.
REQ-033 wr_req addr 0x3FFFF data 0xA55A at phase 1 -> single we_n low pulse one cycle, addr/data stable one cycle before and after, drive never overlapping oe_n.
REQ-034 Simultaneous rd_req and wr_req every period at phase 5 -> both serviced each period, overrun stays 0.
REQ-035 Second rd_req while rd_busy -> overrun=2'b01, first request completes unchanged; overrun_clr -> 2'b00.
REQ-036 reset_n low at phase 4 of a write -> we_n, ce_n high and drive 0 within the same cycle, busy 0; clkPhase forced to 6 mid-read -> access aborted, retried next period.

Source files
------------

// File: rtl/sramfb_pkg.sv
// rtl/sramfb_pkg.sv - shared phase constants and window-state type for the SRAM arbiter
package sramfb_pkg;

    // Pixel-period slots: reads own phases 0-2, writes own phases 3-5.
    localparam logic [2:0] RD_START  = 3'd0;
    localparam logic [2:0] RD_HOLD   = 3'd1;
    localparam logic [2:0] RD_SAMPLE = 3'd2;
    localparam logic [2:0] WR_START  = 3'd3;
    localparam logic [2:0] WR_PULSE  = 3'd4;
    localparam logic [2:0] WR_END    = 3'd5;

    typedef enum logic [2:0] {
        WIN_IDLE,
        WIN_RD,
        WIN_WR_SETUP,
        WIN_WR_PULSE,
        WIN_WR_HOLD
    } win_state_t;

endpackage

// File: rtl/req_slot.sv
// rtl/req_slot.sv - one-deep pending request slot with sticky drop flag
module req_slot #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [ADDR_W+DATA_W-1:0] req_payload,
    input  logic                     done,
    input  logic                     overrun_clr,
    output logic                     busy,
    output logic [ADDR_W+DATA_W-1:0] payload,
    output logic                     overrun
);

    logic load;
    logic drop;

    // A request landing on the completion edge refills the slot, so back-to-back
    // requests one period apart never collide.
    assign load = req && (!busy || done);
    assign drop = req && busy && !done;

    // Slot occupancy, captured payload and sticky drop flag (a drop beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            payload <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                busy    <= 1'b1;
                payload <= req_payload;
            end else if (done) begin
                busy    <= 1'b0;
            end
            overrun <= (overrun && !overrun_clr) || drop;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - phase-slotted read/write arbiter for an asynchronous SRAM
module sram_arbiter
    import sramfb_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        clkPhase,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_busy,
    output logic [1:0]        overrun,
    input  logic              overrun_clr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_drive,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ce_n
);

    win_state_t               state, nxt_state;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [DATA_W-1:0]        wr_data_q;
    logic                     rd_done, wr_done;
    logic [ADDR_W-1:0]        nxt_addr;
    logic [DATA_W-1:0]        nxt_wdata, nxt_rd_data;
    logic                     nxt_drive, nxt_oe_n, nxt_we_n, nxt_ce_n, nxt_rd_valid;

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(0)) u_rd_slot (
        .clk         (clk),
        .rst_n       (reset_n),
        .req         (rd_req),
        .req_payload (rd_addr),
        .done        (rd_done),
        .overrun_clr (overrun_clr),
        .busy        (rd_busy),
        .payload     (rd_addr_q),
        .overrun     (overrun[0])
    );

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_slot (
        .clk         (clk),
        .rst_n       (reset_n),
        .req         (wr_req),
        .req_payload ({wr_addr, wr_data}),
        .done        (wr_done),
        .overrun_clr (overrun_clr),
        .busy        (wr_busy),
        .payload     ({wr_addr_q, wr_data_q}),
        .overrun     (overrun[1])
    );

    // Window sequencing: decide next state and next value of every SRAM-side register.
    // Phases 6/7 fall to the defaults, which abort the access but keep the slots.
    always_comb begin
        nxt_state    = WIN_IDLE;
        nxt_addr     = sram_addr;
        nxt_wdata    = sram_wdata;
        nxt_rd_data  = rd_data;
        nxt_rd_valid = 1'b0;
        nxt_drive    = 1'b0;
        nxt_oe_n     = 1'b1;
        nxt_we_n     = 1'b1;
        nxt_ce_n     = 1'b1;
        rd_done      = 1'b0;
        wr_done      = 1'b0;
        case (clkPhase)
            RD_START: begin
                if (rd_busy) begin
                    nxt_state = WIN_RD;
                    nxt_addr  = rd_addr_q;
                    nxt_ce_n  = 1'b0;
                    nxt_oe_n  = 1'b0;
                end
            end
            RD_HOLD: begin
                if (state == WIN_RD) begin
                    nxt_state = WIN_RD;
                    nxt_ce_n  = 1'b0;
                    nxt_oe_n  = 1'b0;
                end
            end
            RD_SAMPLE: begin
                if (state == WIN_RD) begin
                    nxt_rd_data  = sram_rdata;
                    nxt_rd_valid = 1'b1;
                    rd_done      = 1'b1;
                end
            end
            WR_START: begin
                if (wr_busy) begin
                    nxt_state = WIN_WR_SETUP;
                    nxt_addr  = wr_addr_q;
                    nxt_wdata = wr_data_q;
                    nxt_drive = 1'b1;
                    nxt_ce_n  = 1'b0;
                end
            end
            WR_PULSE: begin
                if (state == WIN_WR_SETUP) begin
                    nxt_state = WIN_WR_PULSE;
                    nxt_drive = 1'b1;
                    nxt_ce_n  = 1'b0;
                    nxt_we_n  = 1'b0;
                end
            end
            WR_END: begin
                // we_n rises here; bus stays driven one more cycle for hold time.
                if (state == WIN_WR_PULSE) begin
                    nxt_state = WIN_WR_HOLD;
                    nxt_drive = 1'b1;
                    nxt_ce_n  = 1'b0;
                    wr_done   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register the window state and all SRAM-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WIN_IDLE;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            sram_drive <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
        end else begin
            state      <= nxt_state;
            sram_addr  <= nxt_addr;
            sram_wdata <= nxt_wdata;
            rd_data    <= nxt_rd_data;
            rd_valid   <= nxt_rd_valid;
            sram_drive <= nxt_drive;
            sram_oe_n  <= nxt_oe_n;
            sram_we_n  <= nxt_we_n;
            sram_ce_n  <= nxt_ce_n;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    clkPhase;
    logic          rd_req, wr_req, overrun_clr;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_busy, rd_valid, wr_busy;
    logic [DW-1:0] rd_data;
    logic [1:0]    overrun;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_drive, sram_oe_n, sram_we_n, sram_ce_n;

    int total = 0;
    int bad   = 0;
    int ph    = 0;
    int rdv_cnt = 0;
    int we_cnt  = 0;
    int viol    = 0;
    logic          we_prev  = 1'b1;
    logic          rdv_prev = 1'b0;
    logic [AW-1:0] we_addr  = '0;
    logic [DW-1:0] we_data  = '0;

    always #5 clk = ~clk;

    // SRAM read model: one marked word, everything else a simple address hash.
    assign sram_rdata = (sram_addr == 18'h01234) ? 16'hBEEF : (sram_addr[15:0] ^ 16'h5A5A);

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clkPhase    (clkPhase),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_busy     (wr_busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_drive  (sram_drive),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n)
    );

    // Bus-protocol monitor: strobe overlaps, write-pulse capture, rd_valid width.
    always @(negedge clk) begin
        if (!sram_oe_n && sram_drive) viol++;
        if (!sram_we_n && (!sram_drive || sram_ce_n)) viol++;
        if (!sram_we_n && we_prev) begin
            we_cnt++;
            we_addr = sram_addr;
            we_data = sram_wdata;
        end
        if (rd_valid) rdv_cnt++;
        if (rd_valid && rdv_prev) viol++;
        we_prev  = sram_we_n;
        rdv_prev = rd_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        overrun_clr = 1'b0;
        ph          = (ph == 5) ? 0 : ph + 1;
        clkPhase    = 3'(ph);
    endtask

    task automatic go_to_phase(input int p);
        for (int i = 0; i < 6 && clkPhase != 3'(p); i++) step();
        chk("reach_phase", 32'(clkPhase), p);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; clkPhase = 3'd0; ph = 0;
        rd_req = 1'b0; wr_req = 1'b0; overrun_clr = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_drive", sram_drive, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_addr", sram_addr, 0);
        step(); step();
        #2 reset_n = 1'b1;
        step();
        chk("post_rst_idle", sram_ce_n, 1);

        // Read request at phase 4, serviced next period.
        go_to_phase(4);
        rd_addr = 18'h01234; rd_req = 1'b1; step();
        chk("t1_busy", rd_busy, 1);
        chk("t1_oe_idle", sram_oe_n, 1);
        step();
        chk("t1_no_early", sram_oe_n, 1);
        step();
        chk("t1_oe_low0", sram_oe_n, 0);
        chk("t1_ce_low", sram_ce_n, 0);
        chk("t1_drive_off", sram_drive, 0);
        chk("t1_addr", sram_addr, 32'h01234);
        step();
        chk("t1_oe_low1", sram_oe_n, 0);
        step();
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, 32'hBEEF);
        chk("t1_oe_high", sram_oe_n, 1);
        chk("t1_ce_high", sram_ce_n, 1);
        chk("t1_busy_clr", rd_busy, 0);
        step();
        chk("t1_valid_pulse", rd_valid, 0);
        chk("t1_data_hold", rd_data, 32'hBEEF);

        // Write request at phase 1 to the top address.
        go_to_phase(1);
        we_cnt = 0;
        wr_addr = 18'h3FFFF; wr_data = 16'hA55A; wr_req = 1'b1; step();
        chk("t2_busy", wr_busy, 1);
        chk("t2_no_drive", sram_drive, 0);
        step();
        chk("t2_no_drive2", sram_drive, 0);
        step();
        chk("t2_setup_drive", sram_drive, 1);
        chk("t2_setup_ce", sram_ce_n, 0);
        chk("t2_setup_we", sram_we_n, 1);
        chk("t2_setup_oe", sram_oe_n, 1);
        chk("t2_setup_addr", sram_addr, 32'h3FFFF);
        chk("t2_setup_data", sram_wdata, 32'hA55A);
        step();
        chk("t2_pulse_we", sram_we_n, 0);
        chk("t2_pulse_addr", sram_addr, 32'h3FFFF);
        chk("t2_pulse_data", sram_wdata, 32'hA55A);
        step();
        chk("t2_hold_we", sram_we_n, 1);
        chk("t2_hold_drive", sram_drive, 1);
        chk("t2_hold_addr", sram_addr, 32'h3FFFF);
        chk("t2_hold_data", sram_wdata, 32'hA55A);
        chk("t2_busy_clr", wr_busy, 0);
        step();
        chk("t2_end_drive", sram_drive, 0);
        chk("t2_end_ce", sram_ce_n, 1);
        chk("t2_we_pulses", we_cnt, 1);
        chk("t2_we_addr", we_addr, 32'h3FFFF);
        chk("t2_we_data", we_data, 32'hA55A);

        // Read and write requested together at phase 5 every period.
        go_to_phase(5);
        rdv_cnt = 0; we_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            rd_addr = 18'(18'h100 + k);
            wr_addr = 18'(18'h200 + k);
            wr_data = 16'(16'h1111 * (k + 1));
            rd_req = 1'b1; wr_req = 1'b1;
            step();
            repeat (5) step();
        end
        step();
        chk("t3_reads", rdv_cnt, 3);
        chk("t3_writes", we_cnt, 3);
        chk("t3_overrun", overrun, 0);
        chk("t3_rd_data", rd_data, 32'h5B58);
        chk("t3_we_addr", we_addr, 32'h00202);
        chk("t3_we_data", we_data, 32'h3333);

        // Second read while busy is dropped; clear coincident with a drop keeps the flag.
        go_to_phase(4);
        rd_addr = 18'h00ABC; rd_req = 1'b1; step();
        chk("t4_busy", rd_busy, 1);
        rd_addr = 18'h00DEF; rd_req = 1'b1; step();
        chk("t4_overrun_set", overrun, 32'h1);
        rd_req = 1'b1; overrun_clr = 1'b1; step();
        chk("t4_clr_vs_drop", overrun, 32'h1);
        chk("t4_addr", sram_addr, 32'h00ABC);
        chk("t4_oe", sram_oe_n, 0);
        step(); step();
        chk("t4_valid", rd_valid, 1);
        chk("t4_data", rd_data, 32'h50E6);
        chk("t4_busy_clr", rd_busy, 0);
        overrun_clr = 1'b1; step();
        chk("t4_overrun_clr", overrun, 0);

        // Reset asserted during the write pulse.
        go_to_phase(1);
        wr_addr = 18'h12345; wr_data = 16'h0F0F; wr_req = 1'b1; step();
        step(); step();
        chk("t5_drive", sram_drive, 1);
        step();
        chk("t5_we_low", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_we", sram_we_n, 1);
        chk("t5_rst_ce", sram_ce_n, 1);
        chk("t5_rst_drive", sram_drive, 0);
        chk("t5_rst_busy", wr_busy, 0);
        chk("t5_rst_addr", sram_addr, 0);
        chk("t5_rst_wdata", sram_wdata, 0);
        step();
        chk("t5_rst_held", sram_drive, 0);
        #2 reset_n = 1'b1;
        step();
        chk("t5_after_ce", sram_ce_n, 1);
        chk("t5_after_busy", wr_busy, 0);

        // Illegal phase aborts a read, which is retried next period.
        go_to_phase(4);
        rd_addr = 18'h00055; rd_req = 1'b1; step();
        step();
        step();
        chk("t6_started", sram_oe_n, 0);
        clkPhase = 3'd6;
        step();
        chk("t6_abort_oe", sram_oe_n, 1);
        chk("t6_abort_ce", sram_ce_n, 1);
        chk("t6_kept", rd_busy, 1);
        step();
        chk("t6_no_valid", rd_valid, 0);
        chk("t6_still_busy", rd_busy, 1);
        go_to_phase(0);
        step();
        chk("t6_retry_oe", sram_oe_n, 0);
        chk("t6_retry_addr", sram_addr, 32'h00055);
        step(); step();
        chk("t6_valid", rd_valid, 1);
        chk("t6_data", rd_data, 32'h5A0F);
        chk("t6_busy_clr", rd_busy, 0);

        chk("protocol_viol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
